// File: rtl/spi_txfifo_unpack.sv
// Byte-wide SPI transmit FIFO: unpacks strobed 32-bit SPITF writes into 1- or 2-byte characters
// delivered over a req/ack handshake. Optional S_TXTHR watermark output under `SPI_TXF_WATERMARK_EN.
module spi_txfifo_unpack #(
    parameter int DEPTH_BYTES   = 32,
    parameter int CHAR_NBITS    = 16,
    parameter int TXF_WATERMARK = 16
) (
    input  logic                         S_SYSCLK,
    input  logic                         S_RESETN,
    input  logic                         S_FLUSH,
    input  logic                         S_WR_EN,
    input  logic [31:0]                  S_WDATA,
    input  logic [3:0]                   S_WSTRB,
    input  logic [3:0]                   S_CHAR_LEN,
    input  logic                         S_CHAR_REQ,
    output logic                         S_CHAR_ACK,
    output logic [CHAR_NBITS-1:0]        S_CHAR_DATA,
    output logic [$clog2(DEPTH_BYTES):0] S_TXCNT,
    output logic                         S_TXE,
    output logic                         S_TNF,
    output logic                         S_OVF
`ifdef SPI_TXF_WATERMARK_EN
    ,
    output logic                         S_TXTHR
`endif
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_BYTES);

    generate
        if ((DEPTH_BYTES < 32'sd8) || (DEPTH_BYTES > 32'sd64) ||
            ((DEPTH_BYTES & (DEPTH_BYTES - 32'sd1)) != 32'sd0) ||
            (CHAR_NBITS < 32'sd9) || (CHAR_NBITS > 32'sd16) ||
            (TXF_WATERMARK < 32'sd0) || (TXF_WATERMARK > DEPTH_BYTES)) begin : g_bad_params
            $error("spi_txfifo_unpack: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [7:0]            mem_r [DEPTH_BYTES];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    state_t                state_r;
    state_t                state_next_s;

    logic                  ack_r;
    logic [CHAR_NBITS-1:0] data_r;
    logic                  ovf_r;
    logic                  txe_r;
    logic                  tnf_r;
    logic [CW-1:0]         txcnt_r;

    logic [2:0]            wr_n_s;
    logic [CW-1:0]         free_s;
    logic                  wr_push_s;
    logic                  wr_ovf_s;
    logic [AW-1:0]         lane_addr_s [4];
    logic [1:0]            need_s;
    logic                  pop_s;
    logic [CW-1:0]         count_next_s;
    logic [15:0]           raw_char_s;
    logic [15:0]           len_mask_s;
    logic [CHAR_NBITS-1:0] char_s;

    // Write admission is all-or-nothing against the free space seen before this cycle's pop.
    always_comb begin
        wr_n_s    = popcount4(S_WSTRB);
        free_s    = DEPTH_C - count_r;
        wr_push_s = 1'b0;
        wr_ovf_s  = 1'b0;
        if (S_WR_EN && !S_FLUSH && (wr_n_s != 3'd0)) begin
            if (free_s >= CW'(wr_n_s)) begin
                wr_push_s = 1'b1;
            end else begin
                wr_ovf_s = 1'b1;
            end
        end else begin
            wr_push_s = 1'b0;
            wr_ovf_s  = 1'b0;
        end
    end

    // Strobed lanes are packed at consecutive addresses; unstrobed lanes consume no slot.
    always_comb begin
        lane_addr_s[0] = wr_ptr_r;
        lane_addr_s[1] = wr_ptr_r + AW'(popcount4({3'b000, S_WSTRB[0]}));
        lane_addr_s[2] = wr_ptr_r + AW'(popcount4({2'b00, S_WSTRB[1:0]}));
        lane_addr_s[3] = wr_ptr_r + AW'(popcount4({1'b0, S_WSTRB[2:0]}));
    end

    // Byte storage; not reset because occupancy is tracked solely by count_r.
    always_ff @(posedge S_SYSCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_push_s && S_WSTRB[i]) begin
                mem_r[lane_addr_s[i]] <= S_WDATA[8*i +: 8];
            end
        end
    end

    // Character assembly: little-endian byte pair, bits above LEN forced to zero.
    always_comb begin
        need_s     = (S_CHAR_LEN > 4'd7) ? 2'd2 : 2'd1;
        raw_char_s = (S_CHAR_LEN > 4'd7) ? {mem_r[rd_ptr_r + AW'(1)], mem_r[rd_ptr_r]}
                                         : {8'h00, mem_r[rd_ptr_r]};
        len_mask_s = (16'd2 << S_CHAR_LEN) - 16'd1;
        char_s     = CHAR_NBITS'(raw_char_s & len_mask_s);
    end

    // Handshake FSM next state; flush overrides and parks in HOLD while req is still high.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        if (S_FLUSH) begin
            state_next_s = S_CHAR_REQ ? ST_HOLD : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (S_CHAR_REQ && (count_r >= CW'(need_s))) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_ACK;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ACK: begin
                    state_next_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!S_CHAR_REQ) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_next_s = count_r;
        if (S_FLUSH) begin
            count_next_s = {CW{1'b0}};
        end else begin
            count_next_s = count_r
                         + (wr_push_s ? CW'(wr_n_s) : {CW{1'b0}})
                         - (pop_s ? CW'(need_s) : {CW{1'b0}});
        end
    end

    // Pointer, count and FSM state registers.
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= ST_IDLE;
        end else if (S_FLUSH) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= state_next_s;
        end else begin
            if (wr_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(wr_n_s);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(need_s);
            end
            count_r <= count_next_s;
            state_r <= state_next_s;
        end
    end

    // Registered handshake and status outputs, all derived from the post-update count.
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            ack_r   <= 1'b0;
            data_r  <= {CHAR_NBITS{1'b0}};
            ovf_r   <= 1'b0;
            txe_r   <= 1'b1;
            tnf_r   <= 1'b1;
            txcnt_r <= DEPTH_C;
        end else begin
            ack_r <= pop_s;
            if (pop_s) begin
                data_r <= char_s;
            end
            ovf_r   <= wr_ovf_s;
            txe_r   <= (count_next_s == {CW{1'b0}});
            tnf_r   <= (count_next_s < DEPTH_C);
            txcnt_r <= DEPTH_C - count_next_s;
        end
    end

    assign S_CHAR_ACK  = ack_r;
    assign S_CHAR_DATA = data_r;
    assign S_OVF       = ovf_r;
    assign S_TXE       = txe_r;
    assign S_TNF       = tnf_r;
    assign S_TXCNT     = txcnt_r;

`ifdef SPI_TXF_WATERMARK_EN
    logic thr_r;

    // Free-space watermark flag feeding the TXT interrupt.
    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            thr_r <= 1'b1;
        end else begin
            thr_r <= ((DEPTH_C - count_next_s) >= CW'(TXF_WATERMARK));
        end
    end

    assign S_TXTHR = thr_r;
`endif

endmodule

// File: tb/tb_spi_txfifo_unpack.sv
// Self-checking bench for spi_txfifo_unpack: directed scenarios then randomized traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_spi_txfifo_unpack;

    localparam int DEPTH = 32;
    localparam int WM    = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush;
    logic        wr_en;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  len;
    logic        req;
    logic        ack;
    logic [15:0] cdata;
    logic [5:0]  txcnt;
    logic        txe;
    logic        tnf;
    logic        ovf;
`ifdef SPI_TXF_WATERMARK_EN
    logic        thr;
`endif

    spi_txfifo_unpack #(
        .DEPTH_BYTES  (DEPTH),
        .CHAR_NBITS   (16),
        .TXF_WATERMARK(WM)
    ) dut (
        .S_SYSCLK   (clk),
        .S_RESETN   (rst_n),
        .S_FLUSH    (flush),
        .S_WR_EN    (wr_en),
        .S_WDATA    (wdata),
        .S_WSTRB    (wstrb),
        .S_CHAR_LEN (len),
        .S_CHAR_REQ (req),
        .S_CHAR_ACK (ack),
        .S_CHAR_DATA(cdata),
        .S_TXCNT    (txcnt),
        .S_TXE      (txe),
        .S_TNF      (tnf),
        .S_OVF      (ovf)
`ifdef SPI_TXF_WATERMARK_EN
        ,
        .S_TXTHR    (thr)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  q[$];
    bit          served;
    bit          ack_cycle;
    logic        exp_ack;
    logic        exp_ovf;
    logic [15:0] exp_data;
    logic [15:0] got[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        served    = 1'b0;
        ack_cycle = 1'b0;
        exp_ack   = 1'b0;
        exp_ovf   = 1'b0;
        exp_data  = 16'h0000;
    endtask

    // One clock of the reference: consumes the inputs currently driven.
    task automatic model_step();
        int   n;
        int   free;
        int   need;
        int   v;
        bit   accept;
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        if (flush) begin
            q.delete();
            served = req;
        end else begin
            n      = $countones(wstrb);
            free   = DEPTH - q.size();
            need   = (len > 4'd7) ? 2 : 1;
            accept = wr_en && (n > 0) && (free >= n);
            if (wr_en && (n > 0) && (free < n)) exp_ovf = 1'b1;
            if (req && !served && (q.size() >= need)) begin
                v = int'(q.pop_front());
                if (need == 2) v = v | (int'(q.pop_front()) << 8);
                v        = v & ((1 << (int'(len) + 1)) - 1);
                exp_data = 16'(v);
                exp_ack  = 1'b1;
                served   = 1'b1;
            end else if (served && !ack_cycle && !req) begin
                served = 1'b0;
            end
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb[i]) q.push_back(wdata[8*i +: 8]);
                end
            end
        end
        ack_cycle = exp_ack;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, "/ack"},   32'(ack),   32'(exp_ack));
        chk({ph, "/data"},  32'(cdata), 32'(exp_data));
        chk({ph, "/ovf"},   32'(ovf),   32'(exp_ovf));
        chk({ph, "/txcnt"}, 32'(txcnt), 32'(DEPTH - q.size()));
        chk({ph, "/txe"},   32'(txe),   32'(q.size() == 0));
        chk({ph, "/tnf"},   32'(tnf),   32'(q.size() < DEPTH));
`ifdef SPI_TXF_WATERMARK_EN
        chk({ph, "/thr"},   32'(thr),   32'((DEPTH - q.size()) >= WM));
`endif
        if (ack === 1'b1) got.push_back(cdata);
    endtask

    task automatic tick(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic cyc(input logic r, input string ph);
        req   = r;
        wr_en = 1'b0;
        flush = 1'b0;
        tick(ph);
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] s, input string ph);
        wr_en = 1'b1;
        wdata = d;
        wstrb = s;
        tick(ph);
        wr_en = 1'b0;
    endtask

    task automatic pop_char(input string ph);
        cyc(1'b1, ph);
        cyc(1'b1, ph);
        cyc(1'b0, ph);
    endtask

    initial begin
        flush = 1'b0; wr_en = 1'b0; wdata = 32'h0; wstrb = 4'h0; len = 4'd7; req = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Four 1-byte characters from one full write
        len = 4'd7;
        wr(32'h04030201, 4'hF, "t1_wr");
        chk("t1_txcnt_after_wr", 32'(txcnt), 32'd28);
        got.delete();
        repeat (4) pop_char("t1_pop");
        chk("t1_nchars", 32'(got.size()), 32'd4);
        chk("t1_c0", 32'(got[0]), 32'h01);
        chk("t1_c1", 32'(got[1]), 32'h02);
        chk("t1_c2", 32'(got[2]), 32'h03);
        chk("t1_c3", 32'(got[3]), 32'h04);
        chk("t1_txcnt_end", 32'(txcnt), 32'd32);
        chk("t1_txe_end", 32'(txe), 32'd1);

        // 16-bit and 12-bit characters
        got.delete();
        len = 4'd15;
        wr(32'h12345678, 4'hF, "t2_wr");
        pop_char("t2_pop");
        pop_char("t2_pop");
        len = 4'd11;
        wr(32'h0000FFFF, 4'h3, "t2_wr12");
        pop_char("t2_pop12");
        chk("t2_c0", 32'(got[0]), 32'h5678);
        chk("t2_c1", 32'(got[1]), 32'h1234);
        chk("t2_c12", 32'(got[2]), 32'h0FFF);

        // Sparse strobe packs lanes 0 and 2
        got.delete();
        len = 4'd7;
        wr(32'hAABBCCDD, 4'h5, "t3_wr");
        chk("t3_txcnt", 32'(txcnt), 32'd30);
        pop_char("t3_pop");
        pop_char("t3_pop");
        chk("t3_c0", 32'(got[0]), 32'hDD);
        chk("t3_c1", 32'(got[1]), 32'hBB);

        // Fill, overflow, then verify oldest bytes survive
        for (int i = 0; i < 8; i++) begin
            wr({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, "t4_fill");
        end
        chk("t4_tnf_full", 32'(tnf), 32'd0);
        chk("t4_txcnt_full", 32'(txcnt), 32'd0);
        wr(32'hDEADBEEF, 4'hF, "t4_ovf_wr");
        chk("t4_ovf_pulse", 32'(ovf), 32'd1);
        cyc(1'b0, "t4_after");
        chk("t4_ovf_clear", 32'(ovf), 32'd0);
        chk("t4_txcnt_kept", 32'(txcnt), 32'd0);
        got.delete();
        repeat (4) pop_char("t4_pop");
        for (int i = 0; i < 4; i++) chk("t4_oldest", 32'(got[i]), 32'(i));
        flush = 1'b1;
        tick("t4_flush");
        flush = 1'b0;

        // 2-byte character waits for its second byte
        len = 4'd15;
        wr(32'h000000AB, 4'h1, "t5_wr1");
        got.delete();
        repeat (3) cyc(1'b1, "t5_wait");
        chk("t5_no_ack", 32'(got.size()), 32'd0);
        wr(32'h000000CD, 4'h1, "t5_wr2");
        chk("t5_no_ack_wr_cycle", 32'(ack), 32'd0);
        cyc(1'b1, "t5_pop");
        chk("t5_ack", 32'(ack), 32'd1);
        chk("t5_data", 32'(cdata), 32'hCDAB);
        cyc(1'b1, "t5_hold");
        cyc(1'b0, "t5_rel");

        // Flush together with req and write: nothing delivered, nothing flagged
        len = 4'd7;
        wr(32'h44332211, 4'hF, "t6_wr");
        got.delete();
        req = 1'b1; wr_en = 1'b1; flush = 1'b1; wdata = 32'h99887766; wstrb = 4'hF;
        tick("t6_flush");
        flush = 1'b0; wr_en = 1'b0;
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_txe", 32'(txe), 32'd1);
        chk("t6_ovf", 32'(ovf), 32'd0);
        cyc(1'b1, "t6_post");
        cyc(1'b1, "t6_post");
        chk("t6_no_stale_ack", 32'(got.size()), 32'd0);
        cyc(1'b0, "t6_rel");

        // Asynchronous reset while an ack is on the output
        wr(32'h00005566, 4'h3, "t7_wr");
        cyc(1'b1, "t7_pop");
        chk("t7_ack_before_rst", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t7_ack_rst", 32'(ack), 32'd0);
        chk("t7_txcnt_rst", 32'(txcnt), 32'd32);
        chk("t7_data_rst", 32'(cdata), 32'd0);
        #2 rst_n = 1'b1;
        got.delete();
        repeat (3) cyc(1'b1, "t7_post");
        chk("t7_no_stale_ack", 32'(got.size()), 32'd0);
        cyc(1'b0, "t7_rel");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            wr_en = ($urandom_range(0, 2) == 0);
            wdata = $urandom();
            wstrb = 4'($urandom_range(0, 15));
            len   = 4'($urandom_range(3, 15));
            req   = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 59) == 0);
            tick("rnd");
        end
        flush = 1'b0; wr_en = 1'b0; req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
